// File: rtl/mul_pkg.sv
// Shared encodings and configuration checks for the iterative radix multiplier.
package mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } mul_state_e;

  // Radix must be 1, 2 or 4 and divide an even width of at least 8.
  function automatic bit bpc_legal(int dw, int bpc);
    return (bpc == 1 || bpc == 2 || bpc == 4) && (dw % bpc == 0) &&
           (dw >= 8) && (dw % 2 == 0);
  endfunction

endpackage

// File: rtl/mul_pp_step.sv
// One combinational radix step: add a partial product into the upper
// accumulator half and shift {acc_hi, multiplier} right by BITS_PER_CYCLE.
module mul_pp_step #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [DATA_WIDTH-1:0] acc_hi,
  input  logic [DATA_WIDTH-1:0] mplr,
  input  logic [DATA_WIDTH-1:0] mcand,
  output logic [DATA_WIDTH-1:0] acc_hi_nxt,
  output logic [DATA_WIDTH-1:0] mplr_nxt
);

  localparam int PPW = DATA_WIDTH + BITS_PER_CYCLE;

  logic [PPW-1:0] pp;
  logic [PPW:0]   sum;

  assign pp  = {{DATA_WIDTH{1'b0}}, mplr[BITS_PER_CYCLE-1:0]} *
               {{BITS_PER_CYCLE{1'b0}}, mcand};
  assign sum = {1'b0, pp} + {{(BITS_PER_CYCLE+1){1'b0}}, acc_hi};

  // Shifted sum always fits DATA_WIDTH because acc_hi stays below mcand.
  assign acc_hi_nxt = DATA_WIDTH'(sum >> BITS_PER_CYCLE);
  assign mplr_nxt   = {sum[BITS_PER_CYCLE-1:0], mplr[DATA_WIDTH-1:BITS_PER_CYCLE]};

endmodule

// File: rtl/mul_iter_radix.sv
// Iterative radix multiplier for MUL/MULH/MULHSU/MULHU with a START/READY/VALID
// handshake, pipeline stall and zero-operand early exit.
//
// state  | meaning
// S_IDLE | READY high, waiting for an accepted START
// S_CALC | retiring BITS_PER_CYCLE multiplier bits per cycle
// S_FIX  | sign fix-up, result selection, one-cycle VALID
module mul_iter_radix
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [1:0]            OP,
  input  logic [DATA_WIDTH-1:0] OPERAND_A,
  input  logic [DATA_WIDTH-1:0] OPERAND_B,
  input  logic                  STALL,
  output logic                  READY,
  output logic                  VALID,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  BUSY
);

  localparam int ITER = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(ITER);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (!bpc_legal(DATA_WIDTH, BITS_PER_CYCLE)) begin : g_cfg_check
    $error("mul_iter_radix: illegal DATA_WIDTH/BITS_PER_CYCLE combination");
  end

  mul_state_e            state;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] acc_hi, mag_a, mag_b;
  logic [DATA_WIDTH-1:0] acc_hi_nxt, mag_a_nxt;
  logic [DATA_WIDTH-1:0] mag_a_in, mag_b_in;
  logic                  neg, neg_in, sa, sb, zero_in;
  logic [1:0]            op_q;
  logic [2*DATA_WIDTH-1:0] prod_raw, prod;

  assign sa       = (OP == OP_MULH) || (OP == OP_MULHSU);
  assign sb       = (OP == OP_MULH);
  assign neg_in   = (sa & OPERAND_A[DATA_WIDTH-1]) ^ (sb & OPERAND_B[DATA_WIDTH-1]);
  assign mag_a_in = (sa && OPERAND_A[DATA_WIDTH-1]) ? -OPERAND_A : OPERAND_A;
  assign mag_b_in = (sb && OPERAND_B[DATA_WIDTH-1]) ? -OPERAND_B : OPERAND_B;
  assign zero_in  = (OPERAND_A == '0) || (OPERAND_B == '0);

  assign prod_raw = {acc_hi, mag_a};
  assign prod     = neg ? -prod_raw : prod_raw;

  mul_pp_step #(
    .DATA_WIDTH    (DATA_WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_pp_step (
    .acc_hi    (acc_hi),
    .mplr      (mag_a),
    .mcand     (mag_b),
    .acc_hi_nxt(acc_hi_nxt),
    .mplr_nxt  (mag_a_nxt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      READY  <= 1'b1;
      BUSY   <= 1'b0;
      VALID  <= 1'b0;
      RESULT <= '0;
      count  <= '0;
      acc_hi <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      neg    <= 1'b0;
      op_q   <= OP_MUL;
    end else if (STALL) begin
      // Everything holds; VALID is a pulse so it must not stretch across a stall.
      VALID <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            // Zero early-out also clears the multiplier so {acc_hi, mag_a} reads 0.
            mag_a  <= zero_in ? '0 : mag_a_in;
            mag_b  <= mag_b_in;
            neg    <= neg_in;
            op_q   <= OP;
            acc_hi <= '0;
            count  <= CNT_INIT;
            state  <= zero_in ? S_FIX : S_CALC;
            READY  <= 1'b0;
            BUSY   <= 1'b1;
          end
        end
        S_CALC: begin
          acc_hi <= acc_hi_nxt;
          mag_a  <= mag_a_nxt;
          count  <= count - CNT_ONE;
          if (count == CNT_ONE) state <= S_FIX;
        end
        S_FIX: begin
          RESULT <= (op_q == OP_MUL) ? prod[DATA_WIDTH-1:0]
                                     : prod[2*DATA_WIDTH-1:DATA_WIDTH];
          VALID  <= 1'b1;
          state  <= S_IDLE;
          READY  <= 1'b1;
          BUSY   <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          READY <= 1'b1;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter_radix.sv
// Scoreboard bench for mul_iter_radix: directed cases plus randomized traffic
// checked against a plain 64-bit arithmetic reference.
module tb_mul_iter_radix;

  localparam int DW   = 32;
  localparam int ITER = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [1:0]    OP = 2'b00;
  logic [DW-1:0] A = '0;
  logic [DW-1:0] B = '0;
  logic          STALL = 1'b0;
  logic          READY, VALID, BUSY;
  logic [DW-1:0] RESULT;

  mul_iter_radix #(.DATA_WIDTH(DW), .BITS_PER_CYCLE(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .OP       (OP),
    .OPERAND_A(A),
    .OPERAND_B(B),
    .STALL    (STALL),
    .READY    (READY),
    .VALID    (VALID),
    .RESULT   (RESULT),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] res;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   prev_valid = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [DW-1:0] ref_mul(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    longint pa, pb;
    logic [63:0] p;
    pa = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
    pb = (op == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = pa * pb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Monitor: pops one expectation per VALID pulse.
  always @(negedge CLK) begin
    if (!RST) begin
      if (VALID) begin
        exp_t e;
        check("valid_single_cycle", 64'(prev_valid), 64'd0);
        check("valid_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("result", 64'(RESULT), 64'(e.res));
          if (e.due >= 0) check("valid_cycle", 64'(cyc), 64'(e.due));
        end
      end
      prev_valid = VALID;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] exp, input int lat, input bit push,
                       input bit rnd_stall);
    int n = 0;
    @(negedge CLK);
    while (!READY && n < 300) begin
      if (rnd_stall) STALL = ($urandom_range(0, 3) == 0);
      @(negedge CLK);
      n++;
    end
    if (!READY) begin
      check("ready_timeout", 64'(READY), 64'd1);
      return;
    end
    STALL = 1'b0;
    START = 1'b1;
    OP = op;
    A = a;
    B = b;
    if (push) sb.push_back('{exp, (lat < 0) ? -1 : cyc + lat});
    @(negedge CLK);
    START = 1'b0;
    OP = 2'($urandom);
    A = $urandom;
    B = $urandom;
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cnt;
    int n;
    logic [1:0] op;
    logic [DW-1:0] a, b;

    repeat (2) @(negedge CLK);
    check("rst_ready", 64'(READY), 64'd1);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_valid", 64'(VALID), 64'd0);
    check("rst_result", 64'(RESULT), 64'd0);
    RST = 1'b0;

    // MUL with READY-low window check
    issue(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, ITER + 2, 1, 0);
    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      if (!READY) cnt++;
      @(negedge CLK);
    end
    check("ready_low_cycles", 64'(cnt), 64'd17);
    check("ready_back", 64'(READY), 64'd1);

    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ITER + 2, 1, 0);
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ITER + 2, 1, 0);
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ITER + 2, 1, 0);
    issue(2'b10, 32'd2, 32'h8000_0000, 32'h0000_0001, ITER + 2, 1, 0);

    // zero early-out followed by a back-to-back accept
    issue(2'b00, 32'd0, 32'h1234_5678, 32'd0, 2, 1, 0);
    issue(2'b11, 32'h0001_0000, 32'h0001_0000, 32'd1, ITER + 2, 1, 0);

    // five stalled cycles mid-CALC
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ITER + 2 + 5, 1, 0);
    repeat (3) @(negedge CLK);
    STALL = 1'b1;
    repeat (5) @(negedge CLK);
    STALL = 1'b0;

    // four stalled cycles covering the CALC->FIX transition and FIX
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ITER + 2 + 4, 1, 0);
    repeat (15) @(negedge CLK);
    STALL = 1'b1;
    repeat (4) @(negedge CLK);
    STALL = 1'b0;

    // START during BUSY is ignored
    issue(2'b00, 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, ITER + 2, 1, 0);
    repeat (4) @(negedge CLK);
    START = 1'b1; OP = 2'b00; A = 32'd5; B = 32'd5;
    repeat (3) @(negedge CLK);
    START = 1'b0;

    // reset mid-operation: no VALID afterwards
    issue(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, '0, -1, 0, 0);
    repeat (7) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_ready", 64'(READY), 64'd1);
    check("midrst_busy", 64'(BUSY), 64'd0);
    check("midrst_valid", 64'(VALID), 64'd0);
    check("midrst_result", 64'(RESULT), 64'd0);
    RST = 1'b0;
    repeat (25) @(negedge CLK);

    // randomized traffic with random stalls
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a = pick();
      b = pick();
      issue(op, a, b, ref_mul(op, a, b), -1, 1, 1);
    end
    STALL = 1'b0;

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
